// File: rtl/q_sys_cpu_debug_mem_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : q_sys_cpu_debug_mem_engine_pkg                               |
// | Description : Shared types, jdo field offsets and command decode helpers   |
// |               for the CPU debug memory engine.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package q_sys_cpu_debug_mem_engine_pkg;

  // Transaction FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

  // Command selected from the three debug-slave strobes
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_e;

  localparam int JDO_W         = 38;
  localparam int DATA_W        = 32;
  localparam int WDOG_W        = 16;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RDFLAG    = 35;
  localparam int JDO_CLRERR    = 34;
  localparam int JDO_WDATA_LSB = 3;

  // Fixed priority: ocimem_a beats ocimem_b beats no_action_a
  function automatic cmd_e pick_cmd(input logic a, input logic b, input logic na);
    cmd_e c;
    if (a)       c = CMD_LOAD;
    else if (b)  c = CMD_WRITE;
    else if (na) c = CMD_READ;
    else         c = CMD_NONE;
    return c;
  endfunction

  // More than one strobe in the same cycle: everything but the winner is lost
  function automatic logic cmd_collision(input logic a, input logic b, input logic na);
    return (a & (b | na)) | (b & na);
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_sys_cpu_debug_mem_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : q_sys_cpu_debug_mem_watchdog                                 |
// | Description : 16-bit transaction watchdog. Cleared when a transaction      |
// |               starts, counts every enabled cycle, flags expiry on the      |
// |               TIMEOUT-th enabled cycle since the clear.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module q_sys_cpu_debug_mem_watchdog
  import q_sys_cpu_debug_mem_engine_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // Count value held during the final allowed cycle
  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance while enabled and saturate at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = enable && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/q_sys_cpu_debug_mem_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : q_sys_cpu_debug_mem_engine                                   |
// | Description : Turns debug-slave ocimem strobes into Avalon-MM reads and    |
// |               writes on the CPU debug RAM, keeping an auto-incrementing    |
// |               address, the monitor data register and ready/error status.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module q_sys_cpu_debug_mem_engine
  import q_sys_cpu_debug_mem_engine_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [DATA_W-1:0]  mon_q,   mon_d;
  logic               ready_q, ready_d;
  logic               err_q,   err_d;

  logic               wd_clear;
  logic               wd_expire;
  logic               in_idle;
  logic               strobe_any;
  cmd_e               cmd;

  logic [ADDR_W-1:0]  jdo_addr;
  logic [DATA_W-1:0]  jdo_wdata;
  logic               jdo_rd;
  logic               jdo_clr;
  logic               unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
  assign jdo_rd     = jdo[JDO_RDFLAG];
  assign jdo_clr    = jdo[JDO_CLRERR];
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDFLAG+1], jdo[JDO_WDATA_LSB-1:0]};

  assign in_idle    = (state_q == ST_IDLE);
  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cmd        = pick_cmd(take_action_ocimem_a, take_action_ocimem_b,
                               take_no_action_ocimem_a);

  // Watchdog runs for the whole life of a transaction, RD_REQ and RD_WAIT included
  q_sys_cpu_debug_mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (!in_idle),
    .expire (wd_expire)
  );

  // Next-state, address, data and status; a bus handshake completing in the
  // final watchdog cycle is honoured rather than aborted
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mon_d    = mon_q;
    ready_d  = ready_q;
    err_d    = err_q;
    wd_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        unique case (cmd)
          CMD_LOAD: begin
            addr_d   = jdo_addr;
            wd_clear = 1'b1;
            if (jdo_clr) err_d = 1'b0;
            if (jdo_rd) begin
              ready_d = 1'b0;
              state_d = ST_RD_REQ;
            end else begin
              ready_d = 1'b1;
            end
          end
          CMD_WRITE: begin
            mon_d    = jdo_wdata;
            ready_d  = 1'b0;
            wd_clear = 1'b1;
            state_d  = ST_WR_REQ;
          end
          CMD_READ: begin
            ready_d  = 1'b0;
            wd_clear = 1'b1;
            state_d  = ST_RD_REQ;
          end
          default: ;
        endcase
        if (cmd_collision(take_action_ocimem_a, take_action_ocimem_b,
                          take_no_action_ocimem_a)) begin
          err_d = 1'b1;
        end
      end

      ST_WR_REQ: begin
        if (!avm_waitrequest) begin
          addr_d  = addr_q + ADDR_W'(1);
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            mon_d   = avm_readdata;
            addr_d  = addr_q + ADDR_W'(1);
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end else if (wd_expire) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          mon_d   = avm_readdata;
          addr_d  = addr_q + ADDR_W'(1);
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Strobes that arrive mid-transaction are lost
    if (!in_idle && strobe_any) err_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Bus strobes decode straight from the state so reset drops them immediately
  assign avm_read       = (state_q == ST_RD_REQ);
  assign avm_write      = (state_q == ST_WR_REQ);
  assign avm_address    = addr_q;
  assign avm_writedata  = mon_q;
  assign avm_byteenable = 4'b1111;
  assign busy           = !in_idle;
  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_q_sys_cpu_debug_mem_engine.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_q_sys_cpu_debug_mem_engine                                |
// | Description : Directed self-checking bench for the debug memory engine.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_q_sys_cpu_debug_mem_engine;

  localparam int AW = 8;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          ta, tb, tna;
  logic          wreq, rdv;
  logic [31:0]   rdata;

  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error, busy;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;

  q_sys_cpu_debug_mem_engine #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta),
    .take_action_ocimem_b    (tb),
    .take_no_action_ocimem_a (tna),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .busy                    (busy),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_byteenable          (avm_byteenable),
    .avm_waitrequest         (wreq),
    .avm_readdata            (rdata),
    .avm_readdatavalid       (rdv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model of what the engine must show this cycle
  logic [AW-1:0] m_addr;
  logic [31:0]   m_mon;
  logic          m_ready, m_err, e_read, e_write, e_busy;

  // Observed bus activity
  int            wr_cycles = 0;
  int            rd_cycles = 0;
  logic [AW-1:0] rd_addrs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j        = '0;
    j[24:17] = a;
    j[35]    = rd;
    j[34]    = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] w);
    logic [37:0] j;
    j       = '0;
    j[34:3] = w;
    return j;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("address", {24'd0, avm_address}, {24'd0, m_addr});
    chk("mondreg", MonDReg, m_mon);
    chk("ready", {31'd0, monitor_ready}, {31'd0, m_ready});
    chk("error", {31'd0, monitor_error}, {31'd0, m_err});
    chk("read", {31'd0, avm_read}, {31'd0, e_read});
    chk("write", {31'd0, avm_write}, {31'd0, e_write});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("byteenable", {28'd0, avm_byteenable}, 32'hF);
    if (e_write) chk("writedata", avm_writedata, m_mon);
  end

  always @(negedge clk) begin
    if (avm_write) wr_cycles++;
    if (avm_read) rd_cycles++;
    if (avm_read && !wreq) rd_addrs.push_back(avm_address);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_phase(input int nwait, input int lat, input logic [31:0] d);
    e_busy = 1'b1;
    e_read = 1'b1;
    for (int i = 0; i < nwait; i++) begin
      wreq = 1'b1;
      step();
    end
    wreq = 1'b0;
    if (lat == 0) begin
      rdv   = 1'b1;
      rdata = d;
    end
    step();
    rdv    = 1'b0;
    e_read = 1'b0;
    if (lat != 0) begin
      for (int i = 1; i < lat; i++) step();
      rdv   = 1'b1;
      rdata = d;
      step();
      rdv = 1'b0;
    end
    e_busy  = 1'b0;
    m_mon   = d;
    m_addr  = m_addr + 8'd1;
    m_ready = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic rd, input logic clr,
                         input int nwait, input int lat, input logic [31:0] d);
    ta  = 1'b1;
    jdo = jdo_a(a, rd, clr);
    step();
    ta  = 1'b0;
    jdo = '0;
    m_addr = a;
    if (clr) m_err = 1'b0;
    if (!rd) begin
      m_ready = 1'b1;
    end else begin
      m_ready = 1'b0;
      read_phase(nwait, lat, d);
    end
  endtask

  task automatic do_na(input int nwait, input int lat, input logic [31:0] d);
    tna = 1'b1;
    step();
    tna     = 1'b0;
    m_ready = 1'b0;
    read_phase(nwait, lat, d);
  endtask

  // collide: no_action_a in the same cycle; poke: no_action_a in first busy cycle
  task automatic do_write(input logic [31:0] w, input int nwait, input bit collide, input bit poke);
    tb  = 1'b1;
    tna = collide;
    jdo = jdo_b(w);
    step();
    tb  = 1'b0;
    tna = 1'b0;
    jdo = '0;
    if (collide) m_err = 1'b1;
    m_mon   = w;
    m_ready = 1'b0;
    e_busy  = 1'b1;
    e_write = 1'b1;
    for (int i = 0; i <= nwait; i++) begin
      wreq = (i < nwait);
      tna  = poke && (i == 0);
      step();
      tna = 1'b0;
      if (poke && i == 0) m_err = 1'b1;
    end
    wreq    = 1'b0;
    e_write = 1'b0;
    e_busy  = 1'b0;
    m_addr  = m_addr + 8'd1;
    m_ready = 1'b1;
  endtask

  initial begin
    int w0, r0, n;
    reset = 1'b1;
    jdo = '0; ta = 1'b0; tb = 1'b0; tna = 1'b0;
    wreq = 1'b0; rdv = 1'b0; rdata = '0;
    m_addr = '0; m_mon = '0; m_ready = 1'b0; m_err = 1'b0;
    e_read = 1'b0; e_write = 1'b0; e_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // 1: address load without read
    do_load(8'h10, 1'b0, 1'b0, 0, 0, 32'h0);
    chk("t1_addr", {24'd0, avm_address}, 32'h10);
    chk("t1_ready", {31'd0, monitor_ready}, 32'h1);
    step();

    // 2: write with three stall cycles
    w0 = wr_cycles;
    do_write(32'hDEADBEEF, 3, 1'b0, 1'b0);
    chk("t2_wr_cycles", wr_cycles - w0, 32'd4);
    chk("t2_addr", {24'd0, avm_address}, 32'h11);
    chk("t2_mondreg", MonDReg, 32'hDEADBEEF);
    step();

    // 3: read, data two cycles after acceptance
    do_na(0, 2, 32'h12345678);
    chk("t3_mondreg", MonDReg, 32'h12345678);
    chk("t3_addr", {24'd0, avm_address}, 32'h12);
    step();

    // 4: reads at 0xFF then wrap to 0x00
    do_load(8'hFF, 1'b1, 1'b0, 1, 0, 32'hCAFEF00D);
    step();
    do_na(0, 1, 32'h0BADF00D);
    n = rd_addrs.size();
    chk("t4_rd_addr0", {24'd0, rd_addrs[n-2]}, 32'hFF);
    chk("t4_rd_addr1", {24'd0, rd_addrs[n-1]}, 32'h00);
    chk("t4_addr", {24'd0, avm_address}, 32'h01);
    step();

    // 5: timeout while stalled in the read request
    r0 = rd_cycles;
    tna = 1'b1;
    step();
    tna = 1'b0; m_ready = 1'b0; e_busy = 1'b1; e_read = 1'b1;
    wreq = 1'b1;
    repeat (TO) step();
    wreq = 1'b0; e_read = 1'b0; e_busy = 1'b0; m_err = 1'b1; m_ready = 1'b1;
    chk("t5_rd_cycles", rd_cycles - r0, 32'd6);
    chk("t5_error", {31'd0, monitor_error}, 32'h1);
    chk("t5_mondreg", MonDReg, 32'h0BADF00D);
    // late data in IDLE must be ignored
    rdv = 1'b1; rdata = 32'hFFFF0000;
    step();
    rdv = 1'b0;
    do_load(8'h40, 1'b0, 1'b1, 0, 0, 32'h0);
    chk("t5_err_clr", {31'd0, monitor_error}, 32'h0);
    // timeout while waiting for read data
    tna = 1'b1;
    step();
    tna = 1'b0; m_ready = 1'b0; e_busy = 1'b1; e_read = 1'b1;
    step();
    e_read = 1'b0;
    repeat (TO - 1) step();
    e_busy = 1'b0; m_err = 1'b1; m_ready = 1'b1;
    chk("t5_wait_to_addr", {24'd0, avm_address}, 32'h40);
    do_load(8'h40, 1'b0, 1'b1, 0, 0, 32'h0);

    // 6: collisions, strobe while busy, reset mid-write
    ta = 1'b1; tb = 1'b1; jdo = jdo_a(8'h20, 1'b0, 1'b0);
    step();
    ta = 1'b0; tb = 1'b0; jdo = '0;
    m_addr = 8'h20; m_ready = 1'b1; m_err = 1'b1;
    chk("t6_coll_err", {31'd0, monitor_error}, 32'h1);
    chk("t6_coll_mon", MonDReg, 32'h0BADF00D);
    do_load(8'h20, 1'b0, 1'b1, 0, 0, 32'h0);
    do_write(32'h55AA55AA, 0, 1'b1, 1'b0);
    chk("t6_bna_addr", {24'd0, avm_address}, 32'h21);
    do_load(8'h21, 1'b0, 1'b1, 0, 0, 32'h0);
    do_write(32'h01234567, 2, 1'b0, 1'b1);
    chk("t6_busy_err", {31'd0, monitor_error}, 32'h1);
    // reset in the middle of a stalled write
    tb = 1'b1; jdo = jdo_b(32'hA5A50F0F);
    step();
    tb = 1'b0; jdo = '0;
    m_mon = 32'hA5A50F0F; m_ready = 1'b0; e_busy = 1'b1; e_write = 1'b1;
    wreq = 1'b1;
    step();
    #2;
    reset = 1'b1;
    m_addr = '0; m_mon = '0; m_ready = 1'b0; m_err = 1'b0;
    e_write = 1'b0; e_busy = 1'b0; e_read = 1'b0;
    #1;
    chk("t6_rst_write", {31'd0, avm_write}, 32'h0);
    chk("t6_rst_busy", {31'd0, busy}, 32'h0);
    chk("t6_rst_mon", MonDReg, 32'h0);
    step();
    reset = 1'b0; wreq = 1'b0;
    step();
    do_load(8'h33, 1'b0, 1'b0, 0, 0, 32'h0);
    chk("t6_after_rst", {24'd0, avm_address}, 32'h33);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
